hs_xfer_src_ctrl: RTL

//  Source-side controller for a 4-phase req/ack bus transfer into another clock domain.

---
 rtl/hs_xfer_src_if.sv | 11 +
 rtl/hs_xfer_src_ctrl.sv | 64 ++++++
 2 files changed

// File: rtl/hs_xfer_src_if.sv
// hs_xfer_src_if: producer valid/ready port plus the req/ack/data link toward the destination domain.
interface hs_xfer_src_if #(parameter int BIT_WIDTH = 8);
  logic                 validA;
  logic                 readyA;
  logic [BIT_WIDTH-1:0] dinA;
  logic [BIT_WIDTH-1:0] dataA;
  logic                 reqA;
  logic                 ackSyncA;
  modport master(input validA, dinA, ackSyncA, output readyA, dataA, reqA);
  modport slave(output validA, dinA, ackSyncA, input readyA, dataA, reqA);
endinterface

// File: rtl/hs_xfer_src_ctrl.sv
// hs_xfer_src_ctrl: source side of a 4-phase req/ack crossing; define HS_TIMEOUT_EN for per-phase timeout with sticky errA.
module hs_xfer_src_ctrl #(
  parameter int BIT_WIDTH      = 8,
  parameter int CNT_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clkA,
  input  logic                 rstA,
  hs_xfer_src_if.master        hs,
  output logic                 doneA,
  output logic [CNT_WIDTH-1:0] xferCntA,
  output logic                 errA,
  input  logic                 clrErrA
);
  localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, RELEASE = 2'd2;
  logic [1:0]           state;
  logic [BIT_WIDTH-1:0] data_q;
  logic                 req_q;
  logic                 accept, got_ack, released, tmo, abort_q;
  assign hs.readyA = state == IDLE && !hs.ackSyncA;
  assign hs.dataA  = data_q;
  assign hs.reqA   = req_q;
  assign accept    = hs.validA && hs.readyA;
  assign got_ack   = state == REQ && hs.ackSyncA;
  assign released  = state == RELEASE && !hs.ackSyncA;
`ifdef HS_TIMEOUT_EN
  localparam int PW = $clog2(TIMEOUT_CYCLES + 1);
  logic [PW-1:0] phase_q;
  logic          err_q;
  // a phase expires only when it did not make progress on this same edge
  assign tmo  = state != IDLE && !got_ack && !released && phase_q == PW'(TIMEOUT_CYCLES - 1);
  assign errA = err_q;
  always_ff @(posedge clkA)
    if (rstA) begin
      phase_q <= '0;
      err_q   <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      phase_q <= (accept || got_ack || released || tmo || state == IDLE) ? '0 : phase_q + PW'(1);
      err_q   <= tmo || (err_q && !clrErrA);
      abort_q <= (state == REQ && tmo) ? 1'b1 : released ? 1'b0 : abort_q;
    end
`else
  logic unused_ok;
  assign tmo       = 1'b0;
  assign abort_q   = 1'b0;
  assign errA      = 1'b0;
  assign unused_ok = clrErrA ^ (TIMEOUT_CYCLES == 0);
`endif
  always_ff @(posedge clkA)
    if (rstA) begin
      state    <= IDLE;
      data_q   <= '0;
      req_q    <= 1'b0;
      doneA    <= 1'b0;
      xferCntA <= '0;
    end else begin
      doneA    <= released && !abort_q;
      xferCntA <= (released && !abort_q) ? xferCntA + CNT_WIDTH'(1) : xferCntA;
      data_q   <= accept ? hs.dinA : data_q;
      req_q    <= accept || (req_q && !got_ack && !(state == REQ && tmo));
      state    <= accept ? REQ : (got_ack || (state == REQ && tmo)) ? RELEASE : released ? IDLE : state;
    end
endmodule
